// File: rtl/seg_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg_scan_decoder
//
// Receiving end of the scanned 4-digit 7-segment display bus. The block
// registers the multiplexed anode/segment lines, waits for each digit to sit
// still for SETTLE_CYCLES samples, decodes the segment pattern back to BCD and
// rebuilds the two-digit score and timer values once all four slots of a frame
// have been seen. A watchdog flags a display that has stopped scanning.
//
// Parameters
//   SETTLE_CYCLES   consecutive identical samples before a digit is captured (>=2)
//   TIMEOUT_CYCLES  cycles without a completed frame before stale asserts
//   TIMEOUT_W       width of the timeout counter (must hold TIMEOUT_CYCLES)
//
// Configuration macro
//   BLANK_TENS_EN   when defined, an all-off pattern (seg=7'h7F) captured in a
//                   tens slot (an[1] or an[3]) decodes as 0 and is not an
//                   error (leading-zero blanking). When undefined, an all-off
//                   pattern is invalid in every slot.
//
// Ports
//   clk          in   1  system clock
//   reset        in   1  asynchronous, active-high reset
//   an           in   4  anode enables, active-low one-hot
//                        an[0]=score ones, an[1]=score tens,
//                        an[2]=timer ones, an[3]=timer tens
//   seg          in   7  segments, active-low, seg[0]=a ... seg[6]=g
//   score_tens   out  4  last captured digit of the slot (4'hF = invalid)
//   score_ones   out  4  last captured digit of the slot (4'hF = invalid)
//   timer_tens   out  4  last captured digit of the slot (4'hF = invalid)
//   timer_ones   out  4  last captured digit of the slot (4'hF = invalid)
//   score_bin    out  7  score_tens*10+score_ones from the last error-free frame
//   timer_bin    out  7  timer_tens*10+timer_ones from the last error-free frame
//   frame_valid  out  1  one-cycle pulse when all four slots have been captured
//   frame_err    out  1  qualified by frame_valid: a slot in the frame was invalid
//   stale        out  1  no frame for TIMEOUT_CYCLES; sticky until next frame
// -----------------------------------------------------------------------------
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000,
    parameter int TIMEOUT_W      = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] an,
    input  logic [6:0] seg,
    output logic [3:0] score_tens,
    output logic [3:0] score_ones,
    output logic [3:0] timer_tens,
    output logic [3:0] timer_ones,
    output logic [6:0] score_bin,
    output logic [6:0] timer_bin,
    output logic       frame_valid,
    output logic       frame_err,
    output logic       stale
);

    localparam int SET_W = $clog2(SETTLE_CYCLES + 1);

    localparam logic [SET_W-1:0]     SETTLE_MAX  = SET_W'(SETTLE_CYCLES);
    localparam logic [SET_W-1:0]     SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(TIMEOUT_CYCLES);

    // Slot numbering follows the anode bit that selects it.
    localparam int SLOT_SCORE_ONES = 0;
    localparam int SLOT_SCORE_TENS = 1;
    localparam int SLOT_TIMER_ONES = 2;
    localparam int SLOT_TIMER_TENS = 3;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
    } scan_t;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    scan_t                 in_q,       in_d;
    logic [SET_W-1:0]      settle_q,   settle_d;
    logic [3:0]            mask_q,     mask_d;
    logic [3:0]            err_q,      err_d;
    logic [3:0][3:0]       digit_q,    digit_d;
    logic [6:0]            score_bin_q, score_bin_d;
    logic [6:0]            timer_bin_q, timer_bin_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  frame_err_q,   frame_err_d;
    logic [TIMEOUT_W-1:0]  tmo_q,      tmo_d;
    logic                  stale_q,    stale_d;

    // -------------------------------------------------------------------------
    // Helpers
    // -------------------------------------------------------------------------
    // Active-low g..a pattern to {valid, digit}; unknown patterns give 4'hF.
    function automatic logic [4:0] decode_seg(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'b1000000: r = {1'b1, 4'd0};
            7'b1111001: r = {1'b1, 4'd1};
            7'b0100100: r = {1'b1, 4'd2};
            7'b0110000: r = {1'b1, 4'd3};
            7'b0011001: r = {1'b1, 4'd4};
            7'b0010010: r = {1'b1, 4'd5};
            7'b0000010: r = {1'b1, 4'd6};
            7'b1111000: r = {1'b1, 4'd7};
            7'b0000000: r = {1'b1, 4'd8};
            7'b0010000: r = {1'b1, 4'd9};
            default:    r = {1'b0, 4'hF};
        endcase
        return r;
    endfunction

    // Only called for error-free frames, so both digits are 0..9 and the
    // result (max 99) always fits in 7 bits.
    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens,
                                              input logic [3:0] ones);
        return ({3'b000, tens} * 7'd10) + {3'b000, ones};
    endfunction

    // -------------------------------------------------------------------------
    // Combinational next-state
    // -------------------------------------------------------------------------
    logic       in_changed;
    logic       slot_hit;
    logic [1:0] slot_idx;
    logic       capture;
    logic [4:0] dec;
    logic [3:0] mask_upd;
    logic [3:0] err_upd;
    logic       frame_done;

    always_comb begin
        // NOTE: every signal written in this block gets a default first, so
        // no path leaves one unassigned and no latch can be inferred.
        in_d          = {an, seg};
        in_changed    = (in_d != in_q);
        settle_d      = settle_q;
        slot_hit      = 1'b0;
        slot_idx      = 2'd0;
        capture       = 1'b0;
        dec           = decode_seg(in_q.seg);
        mask_upd      = mask_q;
        err_upd       = err_q;
        digit_d       = digit_q;
        mask_d        = mask_q;
        err_d         = err_q;
        score_bin_d   = score_bin_q;
        timer_bin_d   = timer_bin_q;
        frame_valid_d = 1'b0;
        frame_err_d   = 1'b0;
        frame_done    = 1'b0;
        tmo_d         = tmo_q;
        stale_d       = stale_q;

        // Settle counter: restart on any change of the sampled bus, otherwise
        // count up and park at SETTLE_CYCLES so a dwell captures only once.
        if (in_changed) begin
            settle_d = SET_W'(1);
        end else if (settle_q != SETTLE_MAX) begin
            settle_d = settle_q + SET_W'(1);
        end

        // Only a single low anode selects a slot; blank or multi-anode
        // patterns let the counter run but never capture.
        case (in_q.an)
            4'b1110: begin slot_hit = 1'b1; slot_idx = 2'(SLOT_SCORE_ONES); end
            4'b1101: begin slot_hit = 1'b1; slot_idx = 2'(SLOT_SCORE_TENS); end
            4'b1011: begin slot_hit = 1'b1; slot_idx = 2'(SLOT_TIMER_ONES); end
            4'b0111: begin slot_hit = 1'b1; slot_idx = 2'(SLOT_TIMER_TENS); end
            default: begin slot_hit = 1'b0; slot_idx = 2'd0;                end
        endcase

        // The capture edge is the one where the counter steps from
        // SETTLE_CYCLES-1 to SETTLE_CYCLES with the bus still unchanged.
        capture = slot_hit && !in_changed && (settle_q == SETTLE_LAST);

`ifdef BLANK_TENS_EN
        // Leading-zero blanking: an unlit tens digit reads as 0.
        if ((in_q.seg == 7'h7F) && slot_idx[0]) begin
            dec = {1'b1, 4'd0};
        end
`endif

        if (capture) begin
            digit_d[slot_idx]  = dec[3:0];
            mask_upd[slot_idx] = 1'b1;
            err_upd[slot_idx]  = ~dec[4];
        end

        frame_done = (mask_upd == 4'b1111);
        mask_d     = frame_done ? 4'b0000 : mask_upd;
        err_d      = frame_done ? 4'b0000 : err_upd;

        if (frame_done) begin
            frame_valid_d = 1'b1;
            frame_err_d   = |err_upd;
            if (!(|err_upd)) begin
                score_bin_d = bcd_to_bin(digit_d[SLOT_SCORE_TENS], digit_d[SLOT_SCORE_ONES]);
                timer_bin_d = bcd_to_bin(digit_d[SLOT_TIMER_TENS], digit_d[SLOT_TIMER_ONES]);
            end
        end

        // Watchdog: a completing frame clears it even on the very cycle the
        // count would have reached the limit.
        if (frame_done) begin
            tmo_d   = '0;
            stale_d = 1'b0;
        end else begin
            if (tmo_q != TIMEOUT_MAX) begin
                tmo_d = tmo_q + TIMEOUT_W'(1);
            end
            stale_d = stale_q | (tmo_d == TIMEOUT_MAX);
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_q          <= {4'hF, 7'h7F};
            settle_q      <= '0;
            mask_q        <= '0;
            err_q         <= '0;
            // NOTE: the digit slots are a four-entry register file whose
            // contents are visible outputs, so they are reset like any flop.
            digit_q       <= '0;
            score_bin_q   <= '0;
            timer_bin_q   <= '0;
            frame_valid_q <= 1'b0;
            frame_err_q   <= 1'b0;
            tmo_q         <= '0;
            stale_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the
            // values from before this edge regardless of statement order.
            in_q          <= in_d;
            settle_q      <= settle_d;
            mask_q        <= mask_d;
            err_q         <= err_d;
            digit_q       <= digit_d;
            score_bin_q   <= score_bin_d;
            timer_bin_q   <= timer_bin_d;
            frame_valid_q <= frame_valid_d;
            frame_err_q   <= frame_err_d;
            tmo_q         <= tmo_d;
            stale_q       <= stale_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign score_ones  = digit_q[SLOT_SCORE_ONES];
    assign score_tens  = digit_q[SLOT_SCORE_TENS];
    assign timer_ones  = digit_q[SLOT_TIMER_ONES];
    assign timer_tens  = digit_q[SLOT_TIMER_TENS];
    assign score_bin   = score_bin_q;
    assign timer_bin   = timer_bin_q;
    assign frame_valid = frame_valid_q;
    assign frame_err   = frame_err_q;
    assign stale       = stale_q;

endmodule
